// File: rtl/noc_out_port.sv
// noc_out_port: per-direction output stage of the mesh router.
// Rotates the one-hot arbitration turn, registers the granted flit onto the
// link, and tracks downstream credits to produce the port-full flag.
module noc_out_port #(
   parameter int CREDITS = 4,
   parameter int CW      = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    N_data_i,
   input  logic [7:0]    S_data_i,
   input  logic [7:0]    E_data_i,
   input  logic [7:0]    W_data_i,
   input  logic [7:0]    L_data_i,
   input  logic [2:0]    port_select,
   input  logic          port_enable,
   input  logic          credit_return,
   output logic [7:0]    data_o,
   output logic          valid_o,
   output logic          port_full,
   output logic [4:0]    turn,
   output logic [CW-1:0] credits,
   output logic [15:0]   flit_count,
   output logic          err
);

   localparam logic [CW-1:0] CREDITS_MAX = CW'(CREDITS);
   localparam logic [4:0]    TURN_RESET  = 5'b10000;

   logic       select_legal;
   logic       transfer;
   logic       saturate;
   logic       protocol_error;
   logic [7:0] selected_data;

   // Pick the flit named by the route logic; illegal selects yield zero and never transfer.
   always_comb begin
      selected_data = 8'h00;
      case (port_select)
         3'b000:  selected_data = N_data_i;
         3'b001:  selected_data = S_data_i;
         3'b010:  selected_data = E_data_i;
         3'b011:  selected_data = W_data_i;
         3'b100:  selected_data = L_data_i;
         default: selected_data = 8'h00;
      endcase
   end

   // Decide whether this cycle moves a flit and whether the route logic or downstream misbehaved.
   always_comb begin
      select_legal   = (port_select <= 3'b100);
      transfer       = port_enable && !port_full && select_legal;
      saturate       = credit_return && !transfer && (credits == CREDITS_MAX);
      protocol_error = saturate
                     || (port_enable && port_full)
                     || (port_enable && !select_legal);
   end

   // Full is purely a view of the credit register so the route logic reacts in the same cycle.
   always_comb begin
      port_full = (credits == '0);
   end

   // Rotate the service turn every cycle, independent of any grant activity.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         turn <= TURN_RESET;
      end else begin
         turn <= {turn[0], turn[4:1]};
      end
   end

   // Register the link: data holds between flits, valid pulses for exactly one cycle per flit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_o  <= 8'h00;
         valid_o <= 1'b0;
      end else begin
         valid_o <= transfer;
         if (transfer) begin
            data_o <= selected_data;
         end
      end
   end

   // Consume a credit per flit sent and restore one per return; a coincident pair cancels out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credits <= CREDITS_MAX;
      end else begin
         if (transfer && !credit_return) begin
            credits <= credits - 1'b1;
         end else if (credit_return && !transfer && (credits != CREDITS_MAX)) begin
            credits <= credits + 1'b1;
         end
      end
   end

   // Count flits sent since reset; the counter is allowed to wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_count <= 16'h0000;
      end else if (transfer) begin
         flit_count <= flit_count + 16'h0001;
      end
   end

   // Latch any protocol violation until the next reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (protocol_error) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_out_port.sv
// tb_noc_out_port: directed, self-checking bench for noc_out_port.
// A reference model tracks turn/credits/err/count; granted flits go into a
// scoreboard queue and are popped when the link shows a valid flit.
module tb_noc_out_port;

   localparam int CREDITS = 4;
   localparam int CW      = 4;

   logic          clk;
   logic          rst;
   logic [7:0]    n_data, s_data, e_data, w_data, l_data;
   logic [2:0]    port_select;
   logic          port_enable;
   logic          credit_return;
   logic [7:0]    data_o;
   logic          valid_o;
   logic          port_full;
   logic [4:0]    turn;
   logic [CW-1:0] credits;
   logic [15:0]   flit_count;
   logic          err;

   int checks;
   int failures;

   logic [7:0]  sb_queue[$];
   logic [4:0]  exp_turn;
   int          exp_credits;
   logic        exp_err;
   logic        exp_valid;
   logic [7:0]  exp_data;
   logic [15:0] exp_count;

   noc_out_port #(.CREDITS(CREDITS), .CW(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .N_data_i      (n_data),
      .S_data_i      (s_data),
      .E_data_i      (e_data),
      .W_data_i      (w_data),
      .L_data_i      (l_data),
      .port_select   (port_select),
      .port_enable   (port_enable),
      .credit_return (credit_return),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .port_full     (port_full),
      .turn          (turn),
      .credits       (credits),
      .flit_count    (flit_count),
      .err           (err)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic modelReset();
      exp_turn    = 5'b10000;
      exp_credits = CREDITS;
      exp_err     = 1'b0;
      exp_valid   = 1'b0;
      exp_data    = 8'h00;
      exp_count   = 16'h0000;
      sb_queue.delete();
   endtask

   task automatic checkOutput(input string step);
      logic [7:0] popped;
      chk({step, ":turn"},       32'(turn),       32'(exp_turn));
      chk({step, ":credits"},    32'(credits),    32'(exp_credits));
      chk({step, ":port_full"},  32'(port_full),  32'(exp_credits == 0));
      chk({step, ":err"},        32'(err),        32'(exp_err));
      chk({step, ":flit_count"}, 32'(flit_count), 32'(exp_count));
      chk({step, ":valid_o"},    32'(valid_o),    32'(exp_valid));
      chk({step, ":data_o"},     32'(data_o),     32'(exp_data));
      if (valid_o === 1'b1) begin
         if (sb_queue.size() == 0) begin
            chk({step, ":sb_empty"}, 32'(1), 32'(0));
         end else begin
            popped = sb_queue.pop_front();
            chk({step, ":sb_data"}, 32'(data_o), 32'(popped));
         end
      end
   endtask

   // Drive one cycle of inputs, predict the edge's effect, then sample #1 after the edge.
   task automatic applyStimulus(input string step, input logic [2:0] sel,
                                input logic en, input logic cr);
      logic       legal;
      logic       xfer;
      logic [7:0] pick;
      port_select   = sel;
      port_enable   = en;
      credit_return = cr;
      legal = (sel <= 3'd4);
      xfer  = en && (exp_credits != 0) && legal;
      case (sel)
         3'd0:    pick = n_data;
         3'd1:    pick = s_data;
         3'd2:    pick = e_data;
         3'd3:    pick = w_data;
         default: pick = l_data;
      endcase
      if ((cr && !xfer && exp_credits == CREDITS) || (en && exp_credits == 0) || (en && !legal))
         exp_err = 1'b1;
      if (xfer && !cr)
         exp_credits = exp_credits - 1;
      else if (cr && !xfer && exp_credits < CREDITS)
         exp_credits = exp_credits + 1;
      if (xfer) begin
         sb_queue.push_back(pick);
         exp_data  = pick;
         exp_count = exp_count + 16'h0001;
      end
      exp_valid = xfer;
      exp_turn  = {exp_turn[0], exp_turn[4:1]};
      @(posedge clk);
      #1;
      checkOutput(step);
   endtask

   task automatic checkResetState(input string step);
      chk({step, ":turn"},       32'(turn),       32'h10);
      chk({step, ":data_o"},     32'(data_o),     32'h00);
      chk({step, ":valid_o"},    32'(valid_o),    32'h0);
      chk({step, ":credits"},    32'(credits),    32'(CREDITS));
      chk({step, ":port_full"},  32'(port_full),  32'h0);
      chk({step, ":flit_count"}, 32'(flit_count), 32'h0);
      chk({step, ":err"},        32'(err),        32'h0);
   endtask

   // Release reset midway between edges so the next edge is the first free-running one.
   task automatic releaseReset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      n_data        = 8'hA0;
      s_data        = 8'h00;
      e_data        = 8'hE0;
      w_data        = 8'h50;
      l_data        = 8'h23;
      port_select   = 3'd0;
      port_enable   = 1'b0;
      credit_return = 1'b0;
      modelReset();

      #3;
      checkResetState("por");
      @(posedge clk);
      #1;
      checkResetState("por_held");
      releaseReset();

      $display("[TB] turn rotation");
      for (int i = 0; i < 6; i++) applyStimulus("idle", 3'd0, 1'b0, 1'b0);

      $display("[TB] single transfer from L");
      applyStimulus("single", 3'd4, 1'b1, 1'b0);
      applyStimulus("single_after", 3'd4, 1'b0, 1'b0);
      applyStimulus("single_ret", 3'd0, 1'b0, 1'b1);

      $display("[TB] credit exhaustion from S");
      for (int i = 0; i < 4; i++) begin
         s_data = 8'h11 + 8'(i);
         applyStimulus("burst_s", 3'd1, 1'b1, 1'b0);
      end
      chk("exhaust:full", 32'(port_full), 32'h1);
      s_data = 8'h15;
      applyStimulus("fifth_grant", 3'd1, 1'b1, 1'b0);
      chk("fifth:err", 32'(err), 32'h1);
      applyStimulus("full_idle", 3'd1, 1'b0, 1'b0);

      $display("[TB] async reset mid-burst");
      applyStimulus("refill", 3'd0, 1'b0, 1'b1);
      applyStimulus("burst_e", 3'd2, 1'b1, 1'b0);
      e_data = 8'hE1;
      port_select = 3'd2;
      port_enable = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checkResetState("async_rst");
      port_enable = 1'b0;
      modelReset();
      releaseReset();

      $display("[TB] simultaneous grant and credit return");
      w_data = 8'h51;
      applyStimulus("w1", 3'd3, 1'b1, 1'b0);
      w_data = 8'h52;
      applyStimulus("w2", 3'd3, 1'b1, 1'b0);
      w_data = 8'h53;
      applyStimulus("grant_and_ret", 3'd3, 1'b1, 1'b1);
      chk("simul:credits", 32'(credits), 32'h2);
      applyStimulus("ret1", 3'd0, 1'b0, 1'b1);
      applyStimulus("ret2", 3'd0, 1'b0, 1'b1);
      chk("ret2:err", 32'(err), 32'h0);
      applyStimulus("ret_sat", 3'd0, 1'b0, 1'b1);
      chk("sat:err", 32'(err), 32'h1);

      $display("[TB] illegal select");
      @(negedge clk);
      rst = 1'b1;
      #1;
      modelReset();
      checkResetState("rst2");
      releaseReset();
      applyStimulus("illegal", 3'b110, 1'b1, 1'b0);
      chk("illegal:err", 32'(err), 32'h1);
      n_data = 8'h9C;
      applyStimulus("after_illegal", 3'd0, 1'b1, 1'b0);
      applyStimulus("final_idle", 3'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noc_out_port.md
# noc_out_port

Per-direction output stage of the mesh router. It sits directly downstream of the route logic and owns the link for one direction (N, S, E, W or L). Each cycle it rotates the one-hot service turn the route logic uses for arbitration. It muxes the granted input flit onto a registered link output and tracks downstream buffer credits to drive the port-full flag back to the route logic.

## Interface
- CREDITS, 4: downstream buffer depth in flits; legal range 1..15.
- CW, 4: credit counter width; must satisfy 2^CW > CREDITS.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- N_data_i  input  8  head flit of the north input (x in [7:4], y in [3:0]).
- S_data_i  input  8  head flit of the south input.
- E_data_i  input  8  head flit of the east input.
- W_data_i  input  8  head flit of the west input.
- L_data_i  input  8  head flit of the local input.
- port_select  input  3  source select from route logic: 000 N, 001 S, 010 E, 011 W, 100 L.
- port_enable  input  1  route logic grants one flit to this output this cycle.
- credit_return  input  1  downstream freed one buffer slot (one pulse per flit).
- data_o  output  8  registered link data.
- valid_o  output  1  registered link valid.
- port_full  output  1  no credits left; feeds the route logic `*_port_full` input.
- turn  output  5  one-hot arbitration turn: 10000 N, 01000 S, 00100 E, 00010 W, 00001 L.
- credits  output  CW  current credit count.
- flit_count  output  16  flits sent since reset; wraps.
- err  output  1  sticky protocol-error flag.

## Operation
- Turn: `turn` rotates right one position every cycle, unconditionally: 10000→01000→00100→00010→00001→10000. The rotation does not depend on grants.
- Accept: a transfer occurs when port_enable=1, port_full=0 and port_select is in 000..100.
  - On a transfer, the selected data_i is registered into data_o, valid_o is set to 1, credits is decremented and flit_count is incremented.
- No transfer: valid_o is 0 the next cycle and data_o holds its previous value.
- Credit return: credit_return=1 increments credits.
- Transfer and credit_return in the same cycle: credits is unchanged.
- Saturation: credit_return while credits==CREDITS with no simultaneous transfer leaves credits at CREDITS and sets err.
- Enable while full: port_enable=1 while port_full=1 causes no transfer, leaves credits unchanged and sets err.
- Illegal select: port_enable=1 with port_select in 101..111 causes no transfer and sets err.
- port_full: combinational, (credits==0).
- err: cleared only by rst.
- flit_count: wraps from 0xFFFF to 0x0000.

## Timing
- Reset: while rst is high, all outputs are asynchronously forced to these values:
  - turn=10000
  - data_o=8'h00
  - valid_o=0
  - credits=CREDITS
  - port_full=0
  - flit_count=0
  - err=0
- The first rising edge after rst deasserts advances turn to 01000.
- Latency: a grant at edge k appears on data_o/valid_o after edge k, and is held for exactly one cycle per flit.
- Full-flag timing: port_full reflects credits combinationally.
  - The route logic sees full in the same cycle the last credit is consumed (the cycle after the edge that consumed it).
  - The route logic sees not-full in the same cycle the returned credit is registered.
- Back-to-back grants on consecutive cycles are legal while credits remain.
- Reset mid-transfer: any pending flit is lost, valid_o drops immediately and credits restore to CREDITS. Downstream must be reset concurrently.

## Test plan
- Turn rotation: release rst, idle for 6 cycles → turn sequence 01000, 00100, 00010, 00001, 10000, 01000.
- Single transfer: L_data_i=8'h23, port_select=100, port_enable=1 for one cycle → next cycle data_o=8'h23, valid_o=1, credits=3; following cycle valid_o=0.
- Credit exhaustion, CREDITS=4: four back-to-back grants from S (data 8'h11..8'h14) → credits 3,2,1,0 and port_full=1 after the fourth. A fifth grant → no valid_o and err=1.
- Simultaneous events: credits=2, grant plus credit_return in the same cycle → credits stays 2 and valid_o=1 next cycle. Then credit_return alone twice → credits=4. A third credit_return → credits=4 and err=1.
- Illegal select: port_select=110, port_enable=1 → valid_o=0, credits unchanged, err=1.
- Async reset mid-stream: assert rst between edges during a burst → all outputs immediately take their reset values, without waiting for a clock edge.
